// File: rtl/riscv_pkg.sv
// Shared types and constants for the load/store unit and its alignment helper.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsuState_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_ILLEGAL  = 2'b10,
        FC_TIMEOUT  = 2'b11
    } faultCause_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store shift and alignment for the
// incoming request, plus extraction/extension of the returned load word.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  reqFunct3,
    input  logic [1:0]  reqLane,
    input  logic [31:0] storeData,
    input  logic [2:0]  loadFunct3,
    input  logic [1:0]  loadLane,
    input  logic [31:0] loadWord,
    output logic [3:0]  byteEn,
    output logic [31:0] storeShifted,
    output logic        aligned,
    output logic        legalFunct3,
    output logic [31:0] loadResult
);

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    // Decode the request size into byte enables, legality and alignment.
    always_comb begin
        byteEn       = 4'b0000;
        aligned      = 1'b0;
        legalFunct3  = 1'b1;
        storeShifted = storeData << {reqLane, 3'b000};
        case (reqFunct3)
            F3_B, F3_BU: begin
                byteEn  = 4'b0001 << reqLane;
                aligned = 1'b1;
            end
            F3_H, F3_HU: begin
                byteEn  = 4'b0011 << reqLane;
                aligned = ~reqLane[0];
            end
            F3_W: begin
                byteEn  = 4'b1111;
                aligned = (reqLane == 2'b00);
            end
            default: legalFunct3 = 1'b0;
        endcase
    end

    // Pick the addressed byte/half out of the bus word and extend it.
    always_comb begin
        laneByte   = 8'(loadWord >> {loadLane, 3'b000});
        laneHalf   = 16'(loadWord >> {loadLane[1], 4'b0000});
        loadResult = 32'h0;
        case (loadFunct3)
            F3_B:    loadResult = {{24{laneByte[7]}}, laneByte};
            F3_BU:   loadResult = {24'h0, laneByte};
            F3_H:    loadResult = {{16{laneHalf[15]}}, laneHalf};
            F3_HU:   loadResult = {16'h0, laneHalf};
            F3_W:    loadResult = loadWord;
            default: loadResult = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns core load/store requests into single-beat bus
// transactions, stalling the core until the access completes or aborts.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] dataAdr,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        stall,
    output logic        fault,
    output logic [1:0]  faultCause,
    output logic        busReq,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [31:0] busWdata,
    output logic [3:0]  busBe,
    input  logic        busGnt,
    input  logic        busRvalid,
    input  logic [31:0] busRdata
);

    lsuState_t   state;
    lsuState_t   nextState;
    logic [15:0] timeoutCount;
    logic [2:0]  funct3Reg;
    logic [1:0]  laneReg;
    logic [3:0]  reqByteEn;
    logic [31:0] reqStoreData;
    logic [31:0] loadResult;
    logic        reqAligned;
    logic        reqLegal;
    logic        oneRequest;
    logic        anyRequest;
    logic        illegalReq;
    logic        misalignedReq;
    logic        startAccess;
    logic        timedOut;
    logic        loadDone;

    lsu_align alignUnit (
        .reqFunct3   (funct3),
        .reqLane     (dataAdr[1:0]),
        .storeData   (writeData),
        .loadFunct3  (funct3Reg),
        .loadLane    (laneReg),
        .loadWord    (busRdata),
        .byteEn      (reqByteEn),
        .storeShifted(reqStoreData),
        .aligned     (reqAligned),
        .legalFunct3 (reqLegal),
        .loadResult  (loadResult)
    );

    assign oneRequest    = memRead ^ memWrite;
    assign anyRequest    = memRead | memWrite;
    assign illegalReq    = (memRead & memWrite) | (anyRequest & ~reqLegal);
    assign misalignedReq = oneRequest & reqLegal & ~reqAligned;
    assign startAccess   = (state == IDLE) & oneRequest & reqLegal & reqAligned;
    assign timedOut      = ((state == REQ) || (state == WAIT)) &&
                           (timeoutCount == 16'(TIMEOUT_CYCLES));

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state, handshake and fault decode; timeout overrides any bus response.
    always_comb begin
        nextState  = state;
        stall      = 1'b0;
        fault      = 1'b0;
        faultCause = FC_NONE;
        busReq     = 1'b0;
        loadDone   = 1'b0;
        case (state)
            IDLE: begin
                if (illegalReq) begin
                    fault      = 1'b1;
                    faultCause = FC_ILLEGAL;
                end else if (misalignedReq) begin
                    fault      = 1'b1;
                    faultCause = FC_MISALIGN;
                end else if (startAccess) begin
                    stall     = 1'b1;
                    nextState = REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (timedOut) begin
                    fault      = 1'b1;
                    faultCause = FC_TIMEOUT;
                    nextState  = DONE;
                end else begin
                    busReq = 1'b1;
                    if (busGnt) begin
                        if (busWe) begin
                            nextState = DONE;
                        end else if (busRvalid) begin
                            loadDone  = 1'b1;
                            nextState = DONE;
                        end else begin
                            nextState = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (timedOut) begin
                    fault      = 1'b1;
                    faultCause = FC_TIMEOUT;
                    nextState  = DONE;
                end else if (busRvalid) begin
                    loadDone  = 1'b1;
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Capture the request on acceptance, run the timeout counter, and latch load results.
    always_ff @(posedge clk) begin
        if (rst) begin
            busWe        <= 1'b0;
            busAddr      <= 32'h0;
            busWdata     <= 32'h0;
            busBe        <= 4'b0000;
            funct3Reg    <= 3'b000;
            laneReg      <= 2'b00;
            timeoutCount <= 16'h0;
            readData     <= 32'h0;
        end else begin
            if (startAccess) begin
                busWe        <= memWrite;
                busAddr      <= {dataAdr[31:2], 2'b00};
                busWdata     <= reqStoreData;
                busBe        <= reqByteEn;
                funct3Reg    <= funct3;
                laneReg      <= dataAdr[1:0];
                timeoutCount <= 16'h0;
            end else if ((state == REQ) || (state == WAIT)) begin
                timeoutCount <= timeoutCount + 16'd1;
            end
            if (timedOut) begin
                readData <= 32'h0;
            end else if (loadDone) begin
                readData <= loadResult;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: scenario tasks drive the core and
// bus sides cycle by cycle, expected transactions go through a scoreboard queue.
module tb_load_store_unit;
    import riscv_pkg::*;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } expTxn_t;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] adr;
        logic [31:0] rdata;
        logic        sameCycle;
        logic [31:0] expData;
        logic [3:0]  expBe;
    } loadVec_t;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] expWdata;
        logic [3:0]  expBe;
    } storeVec_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] adr;
        logic [1:0]  cause;
    } faultVec_t;

    logic        clk;
    logic        rst;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  funct3;
    logic [31:0] dataAdr;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        stall;
    logic        fault;
    logic [1:0]  faultCause;
    logic        busReq;
    logic        busWe;
    logic [31:0] busAddr;
    logic [31:0] busWdata;
    logic [3:0]  busBe;
    logic        busGnt;
    logic        busRvalid;
    logic [31:0] busRdata;

    int          checkCount;
    int          passCount;
    logic [31:0] lastLoad;
    expTxn_t     expQ[$];

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .funct3    (funct3),
        .dataAdr   (dataAdr),
        .writeData (writeData),
        .readData  (readData),
        .stall     (stall),
        .fault     (fault),
        .faultCause(faultCause),
        .busReq    (busReq),
        .busWe     (busWe),
        .busAddr   (busAddr),
        .busWdata  (busWdata),
        .busBe     (busBe),
        .busGnt    (busGnt),
        .busRvalid (busRvalid),
        .busRdata  (busRdata)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        nextCycle();
        nextCycle();
        nextCycle();
        rst = 1'b0;
        #1;
        checkCount++;
        if ({stall, fault, busReq, busWe} !== 4'b0000)
            $display("[TB] FAIL reset_flags: got %b, expected 0000", {stall, fault, busReq, busWe});
        else passCount++;
        checkCount++;
        if (faultCause !== 2'b00) $display("[TB] FAIL reset_cause: got %b, expected 00", faultCause);
        else passCount++;
        checkCount++;
        if ({busAddr, busWdata, busBe} !== 68'h0)
            $display("[TB] FAIL reset_bus: got %h %h %b, expected zeros", busAddr, busWdata, busBe);
        else passCount++;
        checkCount++;
        if (readData !== 32'h0) $display("[TB] FAIL reset_rdata: got %h, expected 00000000", readData);
        else passCount++;
    endtask

    task automatic test_store_word;
        expTxn_t e;
        int      stallCycles;
        nextCycle();
        memWrite  = 1'b1;
        funct3    = F3_W;
        dataAdr   = 32'h0000_0100;
        writeData = 32'hDEAD_BEEF;
        expQ.push_back({1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'h0});
        #1;
        stallCycles = stall ? 1 : 0;
        nextCycle();
        memWrite = 1'b0;
        #1;
        if (stall) stallCycles++;
        e = expQ.pop_front();
        checkCount++;
        if (busReq !== 1'b1) $display("[TB] FAIL sw_busreq: got %b, expected 1", busReq);
        else passCount++;
        checkCount++;
        if ({busWe, busAddr, busWdata, busBe} !== {e.we, e.addr, e.wdata, e.be})
            $display("[TB] FAIL sw_bus: got %b %h %h %b, expected %b %h %h %b",
                     busWe, busAddr, busWdata, busBe, e.we, e.addr, e.wdata, e.be);
        else passCount++;
        nextCycle();
        busGnt = 1'b1;
        #1;
        if (stall) stallCycles++;
        checkCount++;
        if ({busReq, busAddr, busWdata} !== {1'b1, e.addr, e.wdata})
            $display("[TB] FAIL sw_hold: got %b %h %h, expected 1 %h %h", busReq, busAddr, busWdata, e.addr, e.wdata);
        else passCount++;
        nextCycle();
        busGnt = 1'b0;
        #1;
        checkCount++;
        if (stall !== 1'b0) $display("[TB] FAIL sw_done_stall: got %b, expected 0", stall);
        else passCount++;
        checkCount++;
        if (stallCycles != 3) $display("[TB] FAIL sw_stall_len: got %0d, expected 3", stallCycles);
        else passCount++;
        nextCycle();
    endtask

    task automatic test_load_extend;
        loadVec_t tab[6];
        expTxn_t  e;
        tab[0] = {F3_B,  32'h0000_0103, 32'h80FF_FFFF, 1'b0, 32'hFFFF_FF80, 4'b1000};
        tab[1] = {F3_BU, 32'h0000_0103, 32'h80FF_FFFF, 1'b0, 32'h0000_0080, 4'b1000};
        tab[2] = {F3_H,  32'h0000_0102, 32'h8001_1234, 1'b1, 32'hFFFF_8001, 4'b1100};
        tab[3] = {F3_HU, 32'h0000_0102, 32'h8001_1234, 1'b0, 32'h0000_8001, 4'b1100};
        tab[4] = {F3_W,  32'h0000_0104, 32'h1234_5678, 1'b1, 32'h1234_5678, 4'b1111};
        tab[5] = {F3_B,  32'h0000_0101, 32'h0000_7F00, 1'b0, 32'h0000_007F, 4'b0010};
        for (int i = 0; i < 6; i++) begin
            memRead = 1'b1;
            funct3  = tab[i].f3;
            dataAdr = tab[i].adr;
            expQ.push_back({1'b0, tab[i].adr[31:2], 2'b00, 32'h0, tab[i].expBe, tab[i].expData});
            nextCycle();
            memRead  = 1'b0;
            busGnt   = 1'b1;
            busRvalid = tab[i].sameCycle;
            busRdata  = tab[i].rdata;
            #1;
            e = expQ.pop_front();
            checkCount++;
            if ({busReq, busWe, busAddr, busBe} !== {1'b1, e.we, e.addr, e.be})
                $display("[TB] FAIL ld%0d_bus: got %b %b %h %b, expected 1 %b %h %b",
                         i, busReq, busWe, busAddr, busBe, e.we, e.addr, e.be);
            else passCount++;
            nextCycle();
            busGnt = 1'b0;
            if (!tab[i].sameCycle) begin
                busRvalid = 1'b1;
                #1;
                checkCount++;
                if ({busReq, stall} !== 2'b01)
                    $display("[TB] FAIL ld%0d_wait: got %b, expected 01", i, {busReq, stall});
                else passCount++;
                nextCycle();
            end
            busRvalid = 1'b0;
            busRdata  = 32'h0;
            #1;
            checkCount++;
            if ({stall, readData} !== {1'b0, e.rdata})
                $display("[TB] FAIL ld%0d_data: got %b %h, expected 0 %h", i, stall, readData, e.rdata);
            else passCount++;
            lastLoad = e.rdata;
            nextCycle();
        end
    endtask

    task automatic test_store_sub;
        storeVec_t tab[4];
        expTxn_t   e;
        tab[0] = {F3_H, 32'h0000_0102, 32'h0000_1234, 32'h1234_0000, 4'b1100};
        tab[1] = {F3_B, 32'h0000_0101, 32'h0000_00AB, 32'h0000_AB00, 4'b0010};
        tab[2] = {F3_B, 32'h0000_0103, 32'hFFFF_FFC3, 32'hC300_0000, 4'b1000};
        tab[3] = {F3_W, 32'h0000_0108, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111};
        for (int i = 0; i < 4; i++) begin
            memWrite  = 1'b1;
            funct3    = tab[i].f3;
            dataAdr   = tab[i].adr;
            writeData = tab[i].wdata;
            expQ.push_back({1'b1, tab[i].adr[31:2], 2'b00, tab[i].expWdata, tab[i].expBe, lastLoad});
            nextCycle();
            memWrite = 1'b0;
            busGnt   = 1'b1;
            #1;
            e = expQ.pop_front();
            checkCount++;
            if ({busReq, busWe, busAddr, busWdata, busBe} !== {1'b1, e.we, e.addr, e.wdata, e.be})
                $display("[TB] FAIL st%0d_bus: got %b %b %h %h %b, expected 1 %b %h %h %b",
                         i, busReq, busWe, busAddr, busWdata, busBe, e.we, e.addr, e.wdata, e.be);
            else passCount++;
            nextCycle();
            busGnt = 1'b0;
            #1;
            checkCount++;
            if ({stall, readData} !== {1'b0, e.rdata})
                $display("[TB] FAIL st%0d_done: got %b %h, expected 0 %h", i, stall, readData, e.rdata);
            else passCount++;
            nextCycle();
        end
    endtask

    task automatic test_misaligned;
        faultVec_t tab[5];
        tab[0] = {1'b1, 1'b0, F3_W,   32'h0000_0102, 2'b01};
        tab[1] = {1'b0, 1'b1, F3_H,   32'h0000_0101, 2'b01};
        tab[2] = {1'b1, 1'b0, F3_H,   32'h0000_0103, 2'b01};
        tab[3] = {1'b1, 1'b0, 3'b011, 32'h0000_0100, 2'b10};
        tab[4] = {1'b1, 1'b1, F3_W,   32'h0000_0100, 2'b10};
        for (int i = 0; i < 5; i++) begin
            memRead  = tab[i].rd;
            memWrite = tab[i].wr;
            funct3   = tab[i].f3;
            dataAdr  = tab[i].adr;
            #1;
            checkCount++;
            if ({fault, faultCause} !== {1'b1, tab[i].cause})
                $display("[TB] FAIL flt%0d_cause: got %b %b, expected 1 %b", i, fault, faultCause, tab[i].cause);
            else passCount++;
            checkCount++;
            if ({stall, busReq} !== 2'b00)
                $display("[TB] FAIL flt%0d_nostall: got %b, expected 00", i, {stall, busReq});
            else passCount++;
            nextCycle();
            memRead  = 1'b0;
            memWrite = 1'b0;
            #1;
            checkCount++;
            if ({fault, stall, busReq} !== 3'b000)
                $display("[TB] FAIL flt%0d_idle: got %b, expected 000", i, {fault, stall, busReq});
            else passCount++;
            nextCycle();
        end
    endtask

    task automatic test_timeout;
        memRead = 1'b1;
        funct3  = F3_W;
        dataAdr = 32'h0000_0200;
        nextCycle();
        memRead = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkCount++;
            if ({busReq, fault, stall} !== 3'b101)
                $display("[TB] FAIL to_req%0d: got %b, expected 101", k, {busReq, fault, stall});
            else passCount++;
            nextCycle();
        end
        #1;
        checkCount++;
        if ({busReq, fault, faultCause} !== {1'b0, 1'b1, 2'b11})
            $display("[TB] FAIL to_abort: got %b %b %b, expected 0 1 11", busReq, fault, faultCause);
        else passCount++;
        nextCycle();
        #1;
        checkCount++;
        if ({stall, fault, readData} !== {2'b00, 32'h0})
            $display("[TB] FAIL to_done: got %b %b %h, expected 0 0 00000000", stall, fault, readData);
        else passCount++;
        lastLoad = 32'h0;
        nextCycle();
    endtask

    task automatic test_reset_mid_access;
        memRead = 1'b1;
        funct3  = F3_W;
        dataAdr = 32'h0000_0300;
        nextCycle();
        memRead   = 1'b0;
        busGnt    = 1'b1;
        busRvalid = 1'b1;
        busRdata  = 32'hA5A5_A5A5;
        nextCycle();
        busGnt    = 1'b0;
        busRvalid = 1'b0;
        #1;
        checkCount++;
        if (readData !== 32'hA5A5_A5A5) $display("[TB] FAIL rm_preload: got %h, expected a5a5a5a5", readData);
        else passCount++;
        nextCycle();
        memRead = 1'b1;
        dataAdr = 32'h0000_0304;
        nextCycle();
        memRead = 1'b0;
        busGnt  = 1'b1;
        nextCycle();
        busGnt = 1'b0;
        rst    = 1'b1;
        nextCycle();
        rst       = 1'b0;
        busRvalid = 1'b1;
        busRdata  = 32'h1234_5678;
        #1;
        checkCount++;
        if ({busReq, stall, readData} !== {2'b00, 32'h0})
            $display("[TB] FAIL rm_after: got %b %b %h, expected 0 0 00000000", busReq, stall, readData);
        else passCount++;
        nextCycle();
        busRvalid = 1'b0;
        #1;
        checkCount++;
        if ({stall, readData} !== {1'b0, 32'h0})
            $display("[TB] FAIL rm_late: got %b %h, expected 0 00000000", stall, readData);
        else passCount++;
        nextCycle();
    endtask

    // Scenario sequence.
    initial begin
        checkCount = 0;
        passCount  = 0;
        lastLoad   = 32'h0;
        rst        = 1'b1;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        funct3     = 3'b000;
        dataAdr    = 32'h0;
        writeData  = 32'h0;
        busGnt     = 1'b0;
        busRvalid  = 1'b0;
        busRdata   = 32'h0;
        test_reset();
        test_store_word();
        test_load_extend();
        test_store_sub();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
